// File: rtl/cache_fill_ctrl.sv
// Two-way set-associative cache controller: hit decode, store-hit writes,
// LRU upkeep and an 8-word line fill from a single-word read port memory.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | decode hits, service loads/stores, detect misses
//   FILL  | issue 8 word reads, write responses into the victim way
//   META  | install victim tag/valid, age the other way, back to IDLE
module cache_fill_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        hit,
    output logic        stall,
    output logic [15:0] rdata,
    input  logic [15:0] DataOut0,
    input  logic [15:0] DataOut1,
    input  logic [7:0]  MetaDataOut0,
    input  logic [7:0]  MetaDataOut1,
    output logic [15:0] DataIn,
    output logic        WriteEnable0,
    output logic        WriteEnable1,
    output logic [7:0]  MetaDataIn0,
    output logic [7:0]  MetaDataIn1,
    output logic        MetaDataWriteEnable0,
    output logic        MetaDataWriteEnable1,
    output logic [63:0] BlockEnable,
    output logic [7:0]  WordEnable,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        META = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [2:0]  issue_cnt, issue_cnt_next;
    logic [2:0]  recv_cnt, recv_cnt_next;
    logic        issue_done, issue_done_next;
    logic [15:1] addr_q, addr_next;
    logic        victim_q, victim_next;

    logic [5:0]  req_tag;
    logic [5:0]  req_index;
    logic [2:0]  req_word;
    logic        hit0, hit1;
    logic        victim_sel;
    logic        we0, we1, mwe0, mwe1, mreq;
    logic        byte_lane_unused;

    assign req_tag   = req_addr[15:10];
    assign req_index = req_addr[9:4];
    assign req_word  = req_addr[3:1];

    // Byte lane bit plays no part: all accesses are whole 16-bit words.
    assign byte_lane_unused = req_addr[0];

    // Hits are only meaningful while the arrays are addressed by req_addr.
    assign hit0 = (state == IDLE) & req_valid & MetaDataOut0[7]
                  & (MetaDataOut0[5:0] == req_tag);
    assign hit1 = (state == IDLE) & req_valid & MetaDataOut1[7]
                  & (MetaDataOut1[5:0] == req_tag);
    assign hit   = hit0 | hit1;
    assign rdata = hit0 ? DataOut0 : DataOut1;

    // Reset masks every side effect, even if the state register is mid-fill.
    assign WriteEnable0         = we0  & ~rst;
    assign WriteEnable1         = we1  & ~rst;
    assign MetaDataWriteEnable0 = mwe0 & ~rst;
    assign MetaDataWriteEnable1 = mwe1 & ~rst;
    assign mem_req              = mreq & ~rst;

    // Victim choice: fill an empty way first, otherwise evict the LRU way.
    always_comb begin
        victim_sel = 1'b0;
        if (!MetaDataOut0[7])
            victim_sel = 1'b0;
        else if (!MetaDataOut1[7])
            victim_sel = 1'b1;
        else if (MetaDataOut0[6])
            victim_sel = 1'b0;
        else if (MetaDataOut1[6])
            victim_sel = 1'b1;
    end

    // State, counters and miss context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            issue_cnt  <= 3'd0;
            recv_cnt   <= 3'd0;
            issue_done <= 1'b0;
            addr_q     <= '0;
            victim_q   <= 1'b0;
        end else begin
            state      <= state_next;
            issue_cnt  <= issue_cnt_next;
            recv_cnt   <= recv_cnt_next;
            issue_done <= issue_done_next;
            addr_q     <= addr_next;
            victim_q   <= victim_next;
        end
    end

    // Next-state and array/memory control.
    always_comb begin
        state_next      = state;
        issue_cnt_next  = issue_cnt;
        recv_cnt_next   = recv_cnt;
        issue_done_next = issue_done;
        addr_next       = addr_q;
        victim_next     = victim_q;
        stall           = 1'b0;
        DataIn          = 16'h0000;
        we0             = 1'b0;
        we1             = 1'b0;
        MetaDataIn0     = 8'h00;
        MetaDataIn1     = 8'h00;
        mwe0            = 1'b0;
        mwe1            = 1'b0;
        mreq            = 1'b0;
        mem_addr        = {addr_q[15:4], issue_cnt, 1'b0};
        BlockEnable     = 64'd1 << req_index;
        WordEnable      = 8'd1 << req_word;

        case (state)
            IDLE: begin
                if (hit0) begin
                    if (req_write) begin
                        DataIn = req_wdata;
                        we0    = 1'b1;
                    end
                    MetaDataIn0 = {MetaDataOut0[7], 1'b0, MetaDataOut0[5:0]};
                    mwe0        = 1'b1;
                    if (MetaDataOut1[7]) begin
                        MetaDataIn1 = {MetaDataOut1[7], 1'b1, MetaDataOut1[5:0]};
                        mwe1        = 1'b1;
                    end
                end else if (hit1) begin
                    if (req_write) begin
                        DataIn = req_wdata;
                        we1    = 1'b1;
                    end
                    MetaDataIn1 = {MetaDataOut1[7], 1'b0, MetaDataOut1[5:0]};
                    mwe1        = 1'b1;
                    if (MetaDataOut0[7]) begin
                        MetaDataIn0 = {MetaDataOut0[7], 1'b1, MetaDataOut0[5:0]};
                        mwe0        = 1'b1;
                    end
                end else if (req_valid) begin
                    stall       = 1'b1;
                    addr_next   = req_addr[15:1];
                    victim_next = victim_sel;
                    state_next  = FILL;
                end
            end

            FILL: begin
                stall       = 1'b1;
                BlockEnable = 64'd1 << addr_q[9:4];
                WordEnable  = 8'd1 << recv_cnt;
                // Issue side holds at 7 once done so no ninth request goes out.
                if (!issue_done) begin
                    mreq = 1'b1;
                    if (issue_cnt == 3'd7)
                        issue_done_next = 1'b1;
                    else
                        issue_cnt_next = issue_cnt + 3'd1;
                end
                if (mem_rvalid) begin
                    DataIn        = mem_rdata;
                    we0           = ~victim_q;
                    we1           = victim_q;
                    recv_cnt_next = recv_cnt + 3'd1;
                    if (recv_cnt == 3'd7) begin
                        state_next      = META;
                        issue_cnt_next  = 3'd0;
                        issue_done_next = 1'b0;
                    end
                end
            end

            META: begin
                stall       = 1'b1;
                BlockEnable = 64'd1 << addr_q[9:4];
                WordEnable  = 8'd1 << addr_q[3:1];
                if (!victim_q) begin
                    MetaDataIn0 = {1'b1, 1'b0, addr_q[15:10]};
                    mwe0        = 1'b1;
                    if (MetaDataOut1[7]) begin
                        MetaDataIn1 = {MetaDataOut1[7], 1'b1, MetaDataOut1[5:0]};
                        mwe1        = 1'b1;
                    end
                end else begin
                    MetaDataIn1 = {1'b1, 1'b0, addr_q[15:10]};
                    mwe1        = 1'b1;
                    if (MetaDataOut0[7]) begin
                        MetaDataIn0 = {MetaDataOut0[7], 1'b1, MetaDataOut0[5:0]};
                        mwe0        = 1'b1;
                    end
                end
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl with behavioural data/metadata arrays
// and an in-order memory responder (data = address ^ 16'h5A00).
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr  = 16'h0412;
    logic [15:0] req_wdata = 16'h0000;
    logic        hit, stall;
    logic [15:0] rdata;
    logic [15:0] DataOut0, DataOut1;
    logic [7:0]  MetaDataOut0, MetaDataOut1;
    logic [15:0] DataIn;
    logic        WriteEnable0, WriteEnable1;
    logic [7:0]  MetaDataIn0, MetaDataIn1;
    logic        MetaDataWriteEnable0, MetaDataWriteEnable1;
    logic [63:0] BlockEnable;
    logic [7:0]  WordEnable;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_rvalid = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cache_fill_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .hit(hit), .stall(stall), .rdata(rdata),
        .DataOut0(DataOut0), .DataOut1(DataOut1),
        .MetaDataOut0(MetaDataOut0), .MetaDataOut1(MetaDataOut1),
        .DataIn(DataIn), .WriteEnable0(WriteEnable0), .WriteEnable1(WriteEnable1),
        .MetaDataIn0(MetaDataIn0), .MetaDataIn1(MetaDataIn1),
        .MetaDataWriteEnable0(MetaDataWriteEnable0),
        .MetaDataWriteEnable1(MetaDataWriteEnable1),
        .BlockEnable(BlockEnable), .WordEnable(WordEnable),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    // Arrays, logs, memory responder.
    logic [15:0] data0 [64][8] = '{default: '0};
    logic [15:0] data1 [64][8] = '{default: '0};
    logic [7:0]  meta0 [64]    = '{default: '0};
    logic [7:0]  meta1 [64]    = '{default: '0};
    logic [25:0] wr_log [$];
    logic [15:0] mem_log [$];
    logic [15:0] pend_addr [$];
    int          pend_due [$];
    int          cyc = 0, resp_cnt = 0, gap_cnt = 0;
    int          mem_lat = 1, gap_at = -1, gap_len = 0;

    function automatic int idx64(input logic [63:0] v);
        for (int i = 0; i < 64; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int idx8(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    always_comb begin
        DataOut0     = data0[idx64(BlockEnable)][idx8(WordEnable)];
        DataOut1     = data1[idx64(BlockEnable)][idx8(WordEnable)];
        MetaDataOut0 = meta0[idx64(BlockEnable)];
        MetaDataOut1 = meta1[idx64(BlockEnable)];
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (WriteEnable0) data0[idx64(BlockEnable)][idx8(WordEnable)] <= DataIn;
            if (WriteEnable1) data1[idx64(BlockEnable)][idx8(WordEnable)] <= DataIn;
            if (MetaDataWriteEnable0) meta0[idx64(BlockEnable)] <= MetaDataIn0;
            if (MetaDataWriteEnable1) meta1[idx64(BlockEnable)] <= MetaDataIn1;
            if (WriteEnable0 || WriteEnable1)
                wr_log.push_back({WriteEnable1, 6'(idx64(BlockEnable)), 3'(idx8(WordEnable)), DataIn});
            if (mem_rvalid) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
                resp_cnt = resp_cnt + 1;
                gap_cnt  = 0;
            end
            if (mem_req) begin
                pend_addr.push_back(mem_addr);
                pend_due.push_back(cyc + mem_lat - 1);
                mem_log.push_back(mem_addr);
            end
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                if (resp_cnt == gap_at && gap_cnt < gap_len) begin
                    gap_cnt = gap_cnt + 1;
                    mem_rvalid <= 1'b0;
                end else begin
                    mem_rvalid <= 1'b1;
                    mem_rdata  <= pend_addr[0] ^ 16'h5A00;
                end
            end else begin
                mem_rvalid <= 1'b0;
            end
        end
    end

    // Hold a request until stall drops, capturing the META-cycle metadata writes.
    task automatic run_req(input logic [15:0] a, input logic w, input logic [15:0] wd,
                           output logic first_stall, output logic timed_out,
                           output logic saw_meta, output logic [7:0] m0, output logic [7:0] m1,
                           output logic w0, output logic w1);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
        #1;
        first_stall = stall; timed_out = 1'b0; saw_meta = 1'b0;
        m0 = 8'h00; m1 = 8'h00; w0 = 1'b0; w1 = 1'b0;
        while (stall && !timed_out) begin
            if (MetaDataWriteEnable0 || MetaDataWriteEnable1) begin
                saw_meta = 1'b1; m0 = MetaDataIn0; m1 = MetaDataIn1;
                w0 = MetaDataWriteEnable0; w1 = MetaDataWriteEnable1;
            end
            @(negedge clk); #1;
            n++;
            if (n > 300) timed_out = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_addr = 16'h0412;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if ({mem_req, WriteEnable0, WriteEnable1, MetaDataWriteEnable0, MetaDataWriteEnable1} !== 5'b0) begin miscompares++; $display("FAIL rst_enables: got %b want 00000", {mem_req, WriteEnable0, WriteEnable1, MetaDataWriteEnable0, MetaDataWriteEnable1}); end
        @(negedge clk); rst = 1'b0; #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall: got %b want 0", stall); end
        vectors++; if (hit !== 1'b0) begin miscompares++; $display("FAIL rst_hit: got %b want 0", hit); end
        vectors++; if (DataIn !== 16'h0000) begin miscompares++; $display("FAIL rst_datain: got %h want 0000", DataIn); end
        vectors++; if ({MetaDataIn0, MetaDataIn1} !== 16'h0000) begin miscompares++; $display("FAIL rst_metain: got %h want 0000", {MetaDataIn0, MetaDataIn1}); end
        vectors++; if (BlockEnable !== 64'h2) begin miscompares++; $display("FAIL rst_block_en: got %h want 2", BlockEnable); end
        vectors++; if (WordEnable !== 8'h02) begin miscompares++; $display("FAIL rst_word_en: got %h want 02", WordEnable); end
    endtask

    task automatic test_load_fill();
        logic fs, to, sm, w0, w1;
        logic [7:0] m0, m1;
        logic [15:0] ea;
        int wb, mb;
        wb = wr_log.size(); mb = mem_log.size(); mem_lat = 1;
        run_req(16'h0412, 1'b0, 16'h0000, fs, to, sm, m0, m1, w0, w1);
        vectors++; if (fs !== 1'b1) begin miscompares++; $display("FAIL load_miss_stall: got %b want 1", fs); end
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL load_timeout: stall never dropped"); end
        vectors++; if (mem_log.size() - mb != 8) begin miscompares++; $display("FAIL load_req_count: got %0d want 8", mem_log.size() - mb); end
        for (int i = 0; i < 8 && mb + i < mem_log.size(); i++) begin
            ea = 16'h0410 + 16'(2 * i);
            vectors++; if (mem_log[mb + i] !== ea) begin miscompares++; $display("FAIL load_mem_addr[%0d]: got %h want %h", i, mem_log[mb + i], ea); end
        end
        vectors++; if (wr_log.size() - wb != 8) begin miscompares++; $display("FAIL load_write_count: got %0d want 8", wr_log.size() - wb); end
        for (int i = 0; i < 8 && wb + i < wr_log.size(); i++) begin
            ea = (16'h0410 + 16'(2 * i)) ^ 16'h5A00;
            vectors++; if (wr_log[wb + i] !== {1'b0, 6'd1, 3'(i), ea}) begin miscompares++; $display("FAIL load_fill_write[%0d]: got %h want %h", i, wr_log[wb + i], {1'b0, 6'd1, 3'(i), ea}); end
        end
        vectors++; if ({sm, w0, w1, m0} !== {3'b110, 8'h81}) begin miscompares++; $display("FAIL load_meta: got seen=%b we0=%b we1=%b in0=%h want 1 1 0 81", sm, w0, w1, m0); end
        vectors++; if (hit !== 1'b1) begin miscompares++; $display("FAIL load_after_hit: got %b want 1", hit); end
        vectors++; if (rdata !== 16'h5E12) begin miscompares++; $display("FAIL load_rdata: got %h want 5e12", rdata); end
        vectors++; if ({MetaDataWriteEnable0, MetaDataWriteEnable1, MetaDataIn0} !== {2'b10, 8'h81}) begin miscompares++; $display("FAIL load_hit_meta: got we=%b%b in0=%h want 10 81", MetaDataWriteEnable0, MetaDataWriteEnable1, MetaDataIn0); end
        @(negedge clk); req_valid = 1'b0;
    endtask

    task automatic test_store_hit();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0412; req_wdata = 16'hBEEF;
        #1;
        vectors++; if ({hit, stall} !== 2'b10) begin miscompares++; $display("FAIL store_hit: got hit=%b stall=%b want 1 0", hit, stall); end
        vectors++; if ({WriteEnable0, WriteEnable1} !== 2'b10) begin miscompares++; $display("FAIL store_we: got %b%b want 10", WriteEnable0, WriteEnable1); end
        vectors++; if (WordEnable !== 8'h02) begin miscompares++; $display("FAIL store_word_en: got %h want 02", WordEnable); end
        vectors++; if (BlockEnable[1] !== 1'b1) begin miscompares++; $display("FAIL store_block_en: got %h want bit 1 set", BlockEnable); end
        vectors++; if (DataIn !== 16'hBEEF) begin miscompares++; $display("FAIL store_datain: got %h want beef", DataIn); end
        @(negedge clk); req_valid = 1'b0; req_write = 1'b0; #1;
        vectors++; if ({WriteEnable0, WriteEnable1} !== 2'b00) begin miscompares++; $display("FAIL store_we_drop: got %b%b want 00", WriteEnable0, WriteEnable1); end
        @(negedge clk); req_valid = 1'b1; #1;
        vectors++; if (rdata !== 16'hBEEF) begin miscompares++; $display("FAIL store_readback: got %h want beef", rdata); end
        @(negedge clk); req_valid = 1'b0;
    endtask

    task automatic test_victim_lru();
        logic fs, to, sm, w0, w1;
        logic [7:0] m0, m1;
        int wb;
        mem_lat = 1; wb = wr_log.size();
        run_req(16'h0810, 1'b0, 16'h0000, fs, to, sm, m0, m1, w0, w1);
        vectors++; if ({to, sm, w0, w1, m0, m1} !== {4'b0111, 8'hC1, 8'h82}) begin miscompares++; $display("FAIL victim_empty_meta: got to=%b seen=%b we=%b%b in0=%h in1=%h want 0 1 11 c1 82", to, sm, w0, w1, m0, m1); end
        vectors++; if (wr_log.size() - wb != 8 || wr_log[wb][25:19] !== 7'b1_000001) begin miscompares++; $display("FAIL victim_empty_way: got n=%0d first=%h want 8 way1 set1", wr_log.size() - wb, wr_log[wb]); end
        vectors++; if ({hit, rdata} !== {1'b1, 16'h5210}) begin miscompares++; $display("FAIL victim_empty_hit: got hit=%b rdata=%h want 1 5210", hit, rdata); end
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0410; #1;
        vectors++; if ({hit, rdata} !== {1'b1, 16'h5E10}) begin miscompares++; $display("FAIL lru_touch_hit: got hit=%b rdata=%h want 1 5e10", hit, rdata); end
        vectors++; if ({MetaDataWriteEnable0, MetaDataWriteEnable1, MetaDataIn0, MetaDataIn1} !== {2'b11, 8'h81, 8'hC2}) begin miscompares++; $display("FAIL lru_touch_meta: got we=%b%b in0=%h in1=%h want 11 81 c2", MetaDataWriteEnable0, MetaDataWriteEnable1, MetaDataIn0, MetaDataIn1); end
        @(negedge clk); req_valid = 1'b0;
        wb = wr_log.size();
        run_req(16'h0C10, 1'b0, 16'h0000, fs, to, sm, m0, m1, w0, w1);
        vectors++; if ({to, sm, w0, w1, m0, m1} !== {4'b0111, 8'hC1, 8'h83}) begin miscompares++; $display("FAIL victim_lru_meta: got to=%b seen=%b we=%b%b in0=%h in1=%h want 0 1 11 c1 83", to, sm, w0, w1, m0, m1); end
        vectors++; if (wr_log.size() - wb != 8 || wr_log[wb][25] !== 1'b1) begin miscompares++; $display("FAIL victim_lru_way: got n=%0d first=%h want 8 way1", wr_log.size() - wb, wr_log[wb]); end
        vectors++; if ({hit, rdata} !== {1'b1, 16'h5610}) begin miscompares++; $display("FAIL victim_lru_hit: got hit=%b rdata=%h want 1 5610", hit, rdata); end
        @(negedge clk); req_valid = 1'b0;
    endtask

    task automatic test_latency_gap();
        logic fs, to, sm, w0, w1;
        logic [7:0] m0, m1;
        logic [15:0] ea;
        int wb, mb;
        wb = wr_log.size(); mb = mem_log.size();
        mem_lat = 5; gap_at = resp_cnt + 3; gap_len = 3;
        run_req(16'h1234, 1'b0, 16'h0000, fs, to, sm, m0, m1, w0, w1);
        vectors++; if ({fs, to} !== 2'b10) begin miscompares++; $display("FAIL gap_stall: got first=%b timeout=%b want 1 0", fs, to); end
        vectors++; if (mem_log.size() - mb != 8) begin miscompares++; $display("FAIL gap_req_count: got %0d want 8", mem_log.size() - mb); end
        vectors++; if (wr_log.size() - wb != 8) begin miscompares++; $display("FAIL gap_write_count: got %0d want 8", wr_log.size() - wb); end
        for (int i = 0; i < 8 && wb + i < wr_log.size(); i++) begin
            ea = (16'h1230 + 16'(2 * i)) ^ 16'h5A00;
            vectors++; if (wr_log[wb + i] !== {1'b0, 6'd35, 3'(i), ea}) begin miscompares++; $display("FAIL gap_write[%0d]: got %h want %h", i, wr_log[wb + i], {1'b0, 6'd35, 3'(i), ea}); end
        end
        vectors++; if ({sm, w0, w1, m0} !== {3'b110, 8'h84}) begin miscompares++; $display("FAIL gap_meta: got seen=%b we=%b%b in0=%h want 1 10 84", sm, w0, w1, m0); end
        vectors++; if ({hit, rdata} !== {1'b1, 16'h4834}) begin miscompares++; $display("FAIL gap_hit: got hit=%b rdata=%h want 1 4834", hit, rdata); end
        @(negedge clk); req_valid = 1'b0; gap_at = -1; gap_len = 0;
    endtask

    task automatic test_reset_mid_fill();
        logic fs, to, sm, w0, w1;
        logic [7:0] m0, m1;
        logic [15:0] ea;
        int wb, mb, n, strays, bad;
        wb = wr_log.size(); mem_lat = 4;
        @(negedge clk); req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h2040;
        n = 0;
        while (wr_log.size() - wb < 3 && n < 100) begin @(negedge clk); n++; end
        vectors++; if (n >= 100) begin miscompares++; $display("FAIL rstfill_timeout: got %0d writes want 3", wr_log.size() - wb); end
        rst = 1'b1; #1;
        vectors++; if ({mem_req, WriteEnable0, WriteEnable1, MetaDataWriteEnable0, MetaDataWriteEnable1} !== 5'b0) begin miscompares++; $display("FAIL rstfill_enables: got %b want 00000", {mem_req, WriteEnable0, WriteEnable1, MetaDataWriteEnable0, MetaDataWriteEnable1}); end
        @(negedge clk); rst = 1'b0; req_valid = 1'b0; #1;
        vectors++; if ({stall, hit} !== 2'b00) begin miscompares++; $display("FAIL rstfill_idle: got stall=%b hit=%b want 0 0", stall, hit); end
        wb = wr_log.size(); mb = mem_log.size(); strays = 0; bad = 0;
        repeat (12) begin
            if (mem_rvalid) strays++;
            if (WriteEnable0 || WriteEnable1 || mem_req) bad++;
            @(negedge clk); #1;
        end
        vectors++; if (strays == 0) begin miscompares++; $display("FAIL rstfill_strays: got 0 stray responses want >0"); end
        vectors++; if (bad != 0 || wr_log.size() != wb || mem_log.size() != mb) begin miscompares++; $display("FAIL rstfill_stray_writes: got bad=%0d writes=%0d reqs=%0d want 0 0 0", bad, wr_log.size() - wb, mem_log.size() - mb); end
        mem_lat = 1;
        run_req(16'h2040, 1'b0, 16'h0000, fs, to, sm, m0, m1, w0, w1);
        vectors++; if (mem_log.size() - mb != 8 || mem_log[mb] !== 16'h2040) begin miscompares++; $display("FAIL rstfill_restart_req: got n=%0d first=%h want 8 2040", mem_log.size() - mb, mem_log[mb]); end
        vectors++; if (wr_log.size() - wb != 8) begin miscompares++; $display("FAIL rstfill_restart_count: got %0d want 8", wr_log.size() - wb); end
        for (int i = 0; i < 8 && wb + i < wr_log.size(); i++) begin
            ea = (16'h2040 + 16'(2 * i)) ^ 16'h5A00;
            vectors++; if (wr_log[wb + i] !== {1'b0, 6'd4, 3'(i), ea}) begin miscompares++; $display("FAIL rstfill_restart_write[%0d]: got %h want %h", i, wr_log[wb + i], {1'b0, 6'd4, 3'(i), ea}); end
        end
        vectors++; if ({to, hit, rdata} !== {2'b01, 16'h7A40}) begin miscompares++; $display("FAIL rstfill_restart_hit: got to=%b hit=%b rdata=%h want 0 1 7a40", to, hit, rdata); end
        @(negedge clk); req_valid = 1'b0;
    endtask

    task automatic test_idle_quiet();
        logic [15:0] addrs [4] = '{16'h0412, 16'h0810, 16'h1234, 16'h0000};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid = 1'b0; req_write = i[0]; req_addr = addrs[i % 4]; req_wdata = 16'h1111;
            #1;
            vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL idle_stall[%0d]: got %b want 0", i, stall); end
            vectors++; if ({mem_req, WriteEnable0, WriteEnable1, MetaDataWriteEnable0, MetaDataWriteEnable1} !== 5'b0) begin miscompares++; $display("FAIL idle_enables[%0d]: got %b want 00000", i, {mem_req, WriteEnable0, WriteEnable1, MetaDataWriteEnable0, MetaDataWriteEnable1}); end
        end
    endtask

    initial begin
        test_reset();
        test_load_fill();
        test_store_hit();
        test_victim_lru();
        test_latency_gap();
        test_reset_mid_fill();
        test_idle_quiet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk, rst.
REQ-002 SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  access request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  16  byte address: tag[15:10], index[9:4], word[3:1].
- req_wdata  in  16  store data.
- hit  out  1  request hits a valid way in IDLE.
- stall  out  1  requester shall hold all req_* inputs stable while high.
- rdata  out  16  load data from the hit way.
- DataOut0, DataOut1  in  16  way 0/1 data array read data.
- MetaDataOut0, MetaDataOut1  in  8  way 0/1 metadata: [7] valid, [6] LRU, [5:0] tag.
- DataIn  out  16  write data, shared by both data arrays.
- WriteEnable0, WriteEnable1  out  1  data array write enables.
- MetaDataIn0, MetaDataIn1  out  8  metadata write values.
- MetaDataWriteEnable0, MetaDataWriteEnable1  out  1  metadata write enables.
- BlockEnable  out  64  one-hot set select.
- WordEnable  out  8  one-hot word select.
- mem_req  out  1  one-word memory read request.
- mem_addr  out  16  word-aligned memory read address.
- mem_rdata  in  16  memory read data.
- mem_rvalid  in  1  mem_rdata valid; responses are in order, latency >= 1.

Function
REQ-003 SHALL implement FSM states IDLE, FILL and META; reset state is IDLE.
REQ-004 SHALL decode hits in IDLE: hitN = req_valid & MetaDataOutN[7] & (MetaDataOutN[5:0] == tag); hit = hit0 | hit1; if both ways match, way 0 wins.
REQ-005 SHALL drive BlockEnable as one-hot of index: from req_addr in IDLE, from the latched address in FILL/META.
REQ-006 SHALL drive WordEnable as one-hot of req_addr[3:1] in IDLE, and one-hot of the receive counter in FILL.
REQ-007 SHALL make rdata combinational: DataOut0 when hit0, otherwise DataOut1.
REQ-008 SHALL, on a store hit in IDLE, drive DataIn = req_wdata and pulse WriteEnableN of the hit way for one cycle.
REQ-009 SHALL, on any hit in IDLE, write both valid ways' metadata in the same cycle:
- hit way: LRU bit = 0, tag and valid unchanged.
- other way: LRU bit = 1 if valid; no write if invalid.
REQ-010 SHALL, on a miss in IDLE (req_valid & ~hit):
- assert stall;
- latch req_addr;
- select the victim: invalid way 0, else invalid way 1, else the way with LRU = 1, else way 0;
- enter FILL next cycle.
REQ-011 SHALL, in FILL, issue mem_req on 8 consecutive cycles with mem_addr = {tag, index, issue_cnt, 1'b0}, issue_cnt counting 0..7.
REQ-012 SHALL, in FILL, on each mem_rvalid:
- drive DataIn = mem_rdata;
- assert the victim's WriteEnable at word recv_cnt;
- increment recv_cnt.
REQ-013 SHALL leave FILL for META on the cycle the 8th mem_rvalid is accepted; mem_rvalid outside FILL is ignored.
REQ-014 SHALL, in META (one cycle), write victim metadata = {1, 0, latched tag}, and write the other way's metadata with LRU = 1 if that way is valid; then return to IDLE.
REQ-015 SHALL keep stall = 1 throughout FILL and META; in IDLE, stall = req_valid & ~hit.
REQ-016 SHALL let the held request hit in IDLE on the cycle after META; a held store is written at that point.
REQ-017 SHALL NOT assert any write enable when req_valid = 0 in IDLE.
REQ-018 SHALL use 3-bit issue and receive counters that wrap 7 -> 0 only on FILL exit; no mem_req beyond 8 per fill.

Reset
REQ-019 SHALL, on rst, go to IDLE and clear issue_cnt, recv_cnt, the latched address and the victim register.
REQ-020 SHALL, while rst is asserted, drive mem_req, every WriteEnable and every MetaDataWriteEnable to 0.
REQ-021 SHALL apply reset during FILL or META with no further writes or mem_req; outstanding responses are ignored.
REQ-022 SHALL require outputs after reset: stall = 0, hit = 0, DataIn = 0, MetaDataIn0/1 = 0, and BlockEnable/WordEnable = one-hot of req_addr.

Verification
REQ-023 SHALL cover: load to 0x0412 with both ways invalid -> stall; 8 mem_req to 0x0410..0x041E; way 0 filled words 0..7; META writes MetaDataIn0 = 0x81; next cycle hit = 1 and rdata = word 1.
REQ-024 SHALL cover: store 0xBEEF to 0x0412 after fill -> hit0; WriteEnable0 = 1 for one cycle; WordEnable = 0x02; BlockEnable bit 1 set.
REQ-025 SHALL cover: way 0 tag 0x01, way 1 tag 0x02, way 1 LRU = 1; miss with tag 0x03 -> way 1 is victim; META writes MetaDataIn1 = 0x83 and MetaDataIn0 LRU = 1.
REQ-026 SHALL cover: memory latency 5 with a gap in mem_rvalid -> exactly 8 writes in word order; stall held until after META.
REQ-027 SHALL cover: rst asserted after 3 responses -> IDLE next cycle; stray mem_rvalid causes no WriteEnable; a new miss restarts at word 0.
REQ-028 SHALL cover: req_valid = 0 in IDLE for 10 cycles -> stall = 0 and no write enable asserted.
